// File: rtl/riscv_pkg.sv
// Shared RV32 constants and fetch-stage types.
//   OPC_*        major opcodes that fetch predecodes or reports
//   INSTR_*      special instruction words (flush filler, halt idiom)
//   fetch_state_e  fetch FSM state encoding
//   imm_j()      J-type immediate, sign-extended to 32 bits
package riscv_pkg;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] INSTR_HALT = 32'h0000_0063;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its neighbours: instruction memory port,
// execute-stage redirect, and the fetch/decode register handshake.
//   master : the fetch unit
//   slave  : memory, execute and decode as seen from the fetch unit
interface fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        halted;
    logic        misalign;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_instr,
        output if_pc_plus4,
        output halted,
        output misalign
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_instr,
        input  if_pc_plus4,
        input  halted,
        input  misalign
    );

endinterface

// File: rtl/fetch_predecode.sv
// Combinational predecode of the word returned by instruction memory.
//   instr_i    fetched instruction word
//   pc_i       address it was fetched from
//   is_jal_o   word is a JAL
//   is_halt_o  word is the halt idiom BEQ x0,x0,0
//   next_pc_o  sequential successor, or JAL target (wraps modulo 2^32)
module fetch_predecode
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        is_jal_o,
    output logic        is_halt_o,
    output logic [31:0] next_pc_o
);

    assign is_jal_o  = (instr_i[6:0] == OPC_JAL);
    assign is_halt_o = (instr_i == INSTR_HALT);
    assign next_pc_o = is_jal_o ? (pc_i + imm_j(instr_i)) : (pc_i + 32'd4);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, reads instruction memory with zero
// latency, and registers {pc, instr} into the fetch/decode register.
// JAL is redirected at fetch; branches fall through and are corrected by
// execute through the redirect port. Fetch parks on BEQ x0,x0,0.
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   fetch_unit_if.master (memory, redirect, decode handshake, status)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | fetching; captures one instruction per accepted cycle
//   ST_HALT | halt word captured; no captures until a redirect arrives
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         misalign_q, misalign_d;

    logic         is_jal;
    logic         is_halt;
    logic [31:0]  next_pc;
    logic         advance;

    fetch_predecode u_predecode (
        .instr_i   (bus.imem_data),
        .pc_i      (pc_q),
        .is_jal_o  (is_jal),
        .is_halt_o (is_halt),
        .next_pc_o (next_pc)
    );

    assign advance = (state_q == ST_RUN) && (!valid_q || bus.if_ready) && !bus.redirect_valid;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = ST_RUN;
        end else if (advance && is_halt) begin
            state_d = ST_HALT;
        end
    end

    // FSM: outputs
    always_comb begin
        bus.halted = (state_q == ST_HALT);
    end

    // Datapath: redirect beats everything, then capture, then a drain of the
    // last (halt) word while parked.
    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        misalign_d = 1'b0;
        if (bus.redirect_valid) begin
            valid_d    = 1'b0;
            if_instr_d = INSTR_NOP;
            pc_d       = {bus.redirect_pc[31:2], 2'b00};
            misalign_d = |bus.redirect_pc[1:0];
        end else if (advance) begin
            valid_d    = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = bus.imem_data;
            // The halt word is captured but the PC stays on it so memory
            // keeps pointing at the halt address.
            pc_d       = is_halt ? pc_q : next_pc;
        end else if ((state_q == ST_HALT) && bus.if_ready) begin
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= INSTR_NOP;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_valid    = valid_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_pc_plus4 = if_pc_q + 32'd4;
    assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] ADDI0 = 32'h0010_0093;
    localparam logic [31:0] ADDI1 = 32'h0020_0113;
    localparam logic [31:0] JAL16 = 32'h0100_006F;
    localparam logic [31:0] ADDI6 = 32'h0030_0193;
    localparam logic [31:0] JALM8 = 32'hFF9F_F06F;
    localparam logic [31:0] ADDIX = 32'h0040_0213;

    logic clk;
    logic rst;
    logic [31:0] mem [0:63];
    int n_chk;
    int n_fail;

    fetch_unit_if bus_if ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    assign bus_if.imem_data = (bus_if.imem_addr < 32'd256) ? mem[bus_if.imem_addr[7:2]] : INSTR_NOP;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rdy, input logic rv, input logic [31:0] rp);
        bus_if.if_ready       = rdy;
        bus_if.redirect_valid = rv;
        bus_if.redirect_pc    = rp;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) mem[i] = INSTR_NOP;
        mem[0]  = ADDI0;
        mem[1]  = ADDI1;
        mem[2]  = JAL16;
        mem[3]  = INSTR_HALT;
        mem[6]  = ADDI6;
        mem[7]  = JALM8;
        mem[16] = ADDIX;

        rst = 1'b0;
        set_in(1'b1, 1'b0, 32'h0);
        tick();
        tick();
        chk("rst_addr",     bus_if.imem_addr, 32'h0);
        chk("rst_valid",    32'(bus_if.if_valid), 32'h0);
        chk("rst_instr",    bus_if.if_instr, INSTR_NOP);
        chk("rst_pc",       bus_if.if_pc, 32'h0);
        chk("rst_halted",   32'(bus_if.halted), 32'h0);
        chk("rst_misalign", 32'(bus_if.misalign), 32'h0);

        rst = 1'b1;
        tick();
        chk("seq0_valid", 32'(bus_if.if_valid), 32'h1);
        chk("seq0_pc",    bus_if.if_pc, 32'h0);
        chk("seq0_instr", bus_if.if_instr, ADDI0);
        chk("seq0_addr",  bus_if.imem_addr, 32'h4);
        tick();
        chk("seq1_pc",    bus_if.if_pc, 32'h4);
        chk("seq1_instr", bus_if.if_instr, ADDI1);
        tick();
        chk("seq2_pc",    bus_if.if_pc, 32'h8);
        chk("seq2_instr", bus_if.if_instr, JAL16);
        chk("seq2_plus4", bus_if.if_pc_plus4, 32'hC);
        chk("jal_addr",   bus_if.imem_addr, 32'h18);
        tick();
        chk("jal_tgt_pc",    bus_if.if_pc, 32'h18);
        chk("jal_tgt_valid", 32'(bus_if.if_valid), 32'h1);
        chk("jal_tgt_instr", bus_if.if_instr, ADDI6);
        tick();
        chk("jalm8_pc",   bus_if.if_pc, 32'h1C);
        chk("jalm8_addr", bus_if.imem_addr, 32'h14);
        tick();
        chk("jalm8_tgt_pc", bus_if.if_pc, 32'h14);
        chk("jalm8_next",   bus_if.imem_addr, 32'h18);

        // stall at 0x4
        set_in(1'b1, 1'b1, 32'h0);
        tick();
        chk("rd0_valid", 32'(bus_if.if_valid), 32'h0);
        chk("rd0_addr",  bus_if.imem_addr, 32'h0);
        set_in(1'b1, 1'b0, 32'h0);
        tick();
        chk("rd0_pc", bus_if.if_pc, 32'h0);
        tick();
        chk("pre_stall_pc", bus_if.if_pc, 32'h4);
        set_in(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    bus_if.if_pc, 32'h4);
            chk("stall_instr", bus_if.if_instr, ADDI1);
            chk("stall_addr",  bus_if.imem_addr, 32'h8);
            chk("stall_valid", 32'(bus_if.if_valid), 32'h1);
        end
        set_in(1'b1, 1'b0, 32'h0);
        tick();
        chk("resume_pc",   bus_if.if_pc, 32'h8);
        chk("resume_addr", bus_if.imem_addr, 32'h18);

        // redirect while stalled, misaligned target
        set_in(1'b0, 1'b0, 32'h0);
        tick();
        chk("stall2_pc", bus_if.if_pc, 32'h8);
        set_in(1'b0, 1'b1, 32'h42);
        tick();
        chk("mis_pulse", 32'(bus_if.misalign), 32'h1);
        chk("mis_valid", 32'(bus_if.if_valid), 32'h0);
        chk("mis_instr", bus_if.if_instr, INSTR_NOP);
        chk("mis_addr",  bus_if.imem_addr, 32'h40);
        set_in(1'b1, 1'b0, 32'h0);
        tick();
        chk("mis_clear", 32'(bus_if.misalign), 32'h0);
        chk("mis_pc",    bus_if.if_pc, 32'h40);
        chk("mis_ins",   bus_if.if_instr, ADDIX);

        // halt at 0xC
        set_in(1'b1, 1'b1, 32'hC);
        tick();
        chk("h_rd_valid", 32'(bus_if.if_valid), 32'h0);
        set_in(1'b0, 1'b0, 32'h0);
        tick();
        chk("h_valid",  32'(bus_if.if_valid), 32'h1);
        chk("h_pc",     bus_if.if_pc, 32'hC);
        chk("h_instr",  bus_if.if_instr, INSTR_HALT);
        chk("h_halted", 32'(bus_if.halted), 32'h1);
        chk("h_addr",   bus_if.imem_addr, 32'hC);
        tick();
        chk("h_hold_valid", 32'(bus_if.if_valid), 32'h1);
        chk("h_hold_addr",  bus_if.imem_addr, 32'hC);
        set_in(1'b1, 1'b0, 32'h0);
        tick();
        chk("h_drain_valid", 32'(bus_if.if_valid), 32'h0);
        chk("h_drain_halt",  32'(bus_if.halted), 32'h1);
        chk("h_drain_addr",  bus_if.imem_addr, 32'hC);
        tick();
        chk("h_park_valid", 32'(bus_if.if_valid), 32'h0);
        chk("h_park_halt",  32'(bus_if.halted), 32'h1);
        set_in(1'b1, 1'b1, 32'h0);
        tick();
        chk("h_exit_halt", 32'(bus_if.halted), 32'h0);
        chk("h_exit_addr", bus_if.imem_addr, 32'h0);
        set_in(1'b1, 1'b0, 32'h0);
        tick();
        chk("h_exit_pc",    bus_if.if_pc, 32'h0);
        chk("h_exit_valid", 32'(bus_if.if_valid), 32'h1);

        // PC wrap
        set_in(1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", bus_if.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_mis",  32'(bus_if.misalign), 32'h0);
        set_in(1'b1, 1'b0, 32'h0);
        tick();
        chk("wrap_pc",    bus_if.if_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus_if.if_pc_plus4, 32'h0);
        chk("wrap_next",  bus_if.imem_addr, 32'h0);
        tick();
        chk("wrap_pc0", bus_if.if_pc, 32'h0);

        // async reset mid-cycle
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus_if.if_valid), 32'h0);
        chk("arst_addr",  bus_if.imem_addr, 32'h0);
        chk("arst_instr", bus_if.if_instr, INSTR_NOP);
        chk("arst_pc",    bus_if.if_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
